// File: rtl/brg_cgra_multi_link_master_pkg.sv
// Shared types for the CGRA multi-link master: link modes, the manycore packet
// layout, and the helper that stamps the reorder tag into reg_id.
package brg_cgra_xcel_pkg;

    typedef enum logic {
        e_link_rr         = 1'b0,
        e_link_interleave = 1'b1
    } link_mode_e;

    localparam int x_cord_width_gp = 4;
    localparam int y_cord_width_gp = 4;
    localparam int data_width_gp   = 32;
    localparam int addr_width_gp   = 28;
    localparam int op_width_gp     = 2;
    localparam int op_ex_width_gp  = 4;
    localparam int reg_id_width_gp = 5;
    localparam int max_inflight_gp = 16;
    localparam int tag_width_gp    = $clog2(max_inflight_gp);

    typedef struct packed {
        logic [addr_width_gp-1:0]   addr;
        logic [op_width_gp-1:0]     op;
        logic [op_ex_width_gp-1:0]  op_ex;
        logic [reg_id_width_gp-1:0] reg_id;
        logic [data_width_gp-1:0]   payload;
        logic [y_cord_width_gp-1:0] src_y_cord;
        logic [x_cord_width_gp-1:0] src_x_cord;
        logic [y_cord_width_gp-1:0] y_cord;
        logic [x_cord_width_gp-1:0] x_cord;
    } bsg_manycore_packet_s;

    localparam int packet_width_gp = $bits(bsg_manycore_packet_s);

    function automatic bsg_manycore_packet_s set_reg_id(
        input bsg_manycore_packet_s       pkt,
        input logic [reg_id_width_gp-1:0] id
    );
        bsg_manycore_packet_s r;
        r        = pkt;
        r.reg_id = id;
        return r;
    endfunction

endpackage

// File: rtl/brg_cgra_multi_link_master_if.sv
// Accelerator-side request/response handshake plus the per-link endpoint bundle.
interface brg_cgra_multi_link_master_if
    import brg_cgra_xcel_pkg::*;
#(
    parameter int num_links_p    = 4,
    parameter int data_width_p   = data_width_gp,
    parameter int packet_width_p = packet_width_gp,
    parameter int credit_width_p = 6
);
    logic                                         mode_i;
    logic                                         req_v_i;
    logic [packet_width_p-1:0]                    req_packet_i;
    logic                                         req_ready_o;
    logic [num_links_p-1:0]                       out_v_o;
    logic [num_links_p-1:0][packet_width_p-1:0]   out_packet_o;
    logic [num_links_p-1:0]                       out_credit_or_ready_i;
    logic [num_links_p-1:0][credit_width_p-1:0]   out_credits_i;
    logic [num_links_p-1:0][data_width_p-1:0]     returned_data_r_i;
    logic [num_links_p-1:0][reg_id_width_gp-1:0]  returned_reg_id_r_i;
    logic [num_links_p-1:0]                       returned_v_r_i;
    logic [num_links_p-1:0]                       returned_yumi_o;
    logic                                         resp_v_o;
    logic [data_width_p-1:0]                      resp_data_o;
    logic                                         resp_yumi_i;

    modport master (
        input  mode_i, req_v_i, req_packet_i,
        output req_ready_o, out_v_o, out_packet_o,
        input  out_credit_or_ready_i, out_credits_i,
        input  returned_data_r_i, returned_reg_id_r_i, returned_v_r_i,
        output returned_yumi_o, resp_v_o, resp_data_o,
        input  resp_yumi_i
    );

    modport slave (
        output mode_i, req_v_i, req_packet_i,
        input  req_ready_o, out_v_o, out_packet_o,
        output out_credit_or_ready_i, out_credits_i,
        output returned_data_r_i, returned_reg_id_r_i, returned_v_r_i,
        input  returned_yumi_o, resp_v_o, resp_data_o,
        output resp_yumi_i
    );

endinterface

// File: rtl/brg_cgra_multi_link_master_rob.sv
// Reorder buffer: tags allocate in order, any port may fill any pending entry,
// and entries retire strictly from the head.
module brg_cgra_rob
    import brg_cgra_xcel_pkg::*;
#(
    parameter int depth_p      = 16,
    parameter int num_ports_p  = 4,
    parameter int data_width_p = 32,
    parameter int tag_width_p  = $clog2(depth_p)
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic                                       alloc_v_i,
    output logic [tag_width_p-1:0]                     alloc_tag_o,
    output logic                                       full_o,
    output logic                                       empty_o,
    input  logic [num_ports_p-1:0]                     wr_v_i,
    input  logic [num_ports_p-1:0][reg_id_width_gp-1:0] wr_tag_i,
    input  logic [num_ports_p-1:0][data_width_p-1:0]   wr_data_i,
    output logic                                       head_v_o,
    output logic [data_width_p-1:0]                    head_data_o,
    input  logic                                       retire_i
);
    localparam int cnt_width_lp = tag_width_p + 1;

    logic [depth_p-1:0]                   valid_q, valid_d;
    logic [depth_p-1:0]                   pend_q, pend_d;
    logic [depth_p-1:0][data_width_p-1:0] data_q, data_d;
    logic [tag_width_p-1:0]               iptr_q, iptr_d;
    logic [tag_width_p-1:0]               rptr_q, rptr_d;
    logic [cnt_width_lp-1:0]              cnt_q, cnt_d;

    always_comb begin
        valid_d = valid_q;
        pend_d  = pend_q;
        data_d  = data_q;
        iptr_d  = iptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (alloc_v_i) begin
            valid_d[iptr_q] = 1'b0;
            pend_d[iptr_q]  = 1'b1;
            iptr_d          = iptr_q + tag_width_p'(1);
        end
        // Tags outside the buffer or aimed at idle entries are stale; drop them.
        for (int p = 0; p < num_ports_p; p++) begin
            if (wr_v_i[p] && ((wr_tag_i[p] >> tag_width_p) == '0)
                && pend_q[wr_tag_i[p][tag_width_p-1:0]]) begin
                valid_d[wr_tag_i[p][tag_width_p-1:0]] = 1'b1;
                data_d[wr_tag_i[p][tag_width_p-1:0]]  = wr_data_i[p];
            end
        end
        if (retire_i) begin
            valid_d[rptr_q] = 1'b0;
            pend_d[rptr_q]  = 1'b0;
            rptr_d          = rptr_q + tag_width_p'(1);
        end
        case ({alloc_v_i, retire_i})
            2'b10:   cnt_d = cnt_q + cnt_width_lp'(1);
            2'b01:   cnt_d = cnt_q - cnt_width_lp'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            pend_q  <= '0;
            data_q  <= '0;
            iptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            iptr_q  <= iptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alloc_tag_o = iptr_q;
    assign full_o      = (cnt_q == cnt_width_lp'(depth_p));
    assign empty_o     = (cnt_q == '0);
    assign head_v_o    = valid_q[rptr_q];
    assign head_data_o = data_q[rptr_q];

endmodule

// File: rtl/brg_cgra_multi_link_master.sv
// Spreads one accelerator request stream over several endpoint links and
// returns responses to the accelerator in issue order.
module brg_cgra_multi_link_master
    import brg_cgra_xcel_pkg::*;
#(
    parameter int num_links_p        = 4,
    parameter int max_inflight_p     = max_inflight_gp,
    parameter int interleave_shift_p = 2,
    parameter int x_cord_width_p     = x_cord_width_gp,
    parameter int y_cord_width_p     = y_cord_width_gp,
    parameter int data_width_p       = data_width_gp,
    parameter int addr_width_p       = addr_width_gp,
    parameter int max_out_credits_p  = 32
) (
    input logic                          clk_i,
    input logic                          reset_i,
    brg_cgra_multi_link_master_if.master bus
);
    localparam int packet_width_lp = addr_width_p + op_width_gp + op_ex_width_gp
                                   + reg_id_width_gp + data_width_p
                                   + 2 * (x_cord_width_p + y_cord_width_p);
    localparam int credit_width_lp = $clog2(max_out_credits_p + 1);
    localparam int link_width_lp   = (num_links_p > 1) ? $clog2(num_links_p) : 1;
    localparam int tag_width_lp    = $clog2(max_inflight_p);

    logic [packet_width_lp-1:0] req_raw;
    bsg_manycore_packet_s       req_pkt, out_pkt;
    logic [addr_width_gp-1:0]   il_bits;
    logic [link_width_lp-1:0]   il_link, sel_link, rr_ptr_q, rr_ptr_d;
    logic [num_links_p-1:0]     link_ok, ret_v;
    logic                       sel_v, issue, retire;
    logic                       rob_full, rob_empty, head_v;
    logic [tag_width_lp-1:0]    alloc_tag;
    link_mode_e                 mode_q;

    assign req_raw = bus.req_packet_i;
    assign req_pkt = bsg_manycore_packet_s'(req_raw);

    for (genvar g = 0; g < num_links_p; g++) begin : g_link
        logic [credit_width_lp-1:0] cred;
        assign cred         = bus.out_credits_i[g];
        assign link_ok[g]   = bus.out_credit_or_ready_i[g] & (cred != '0);
        assign bus.out_packet_o[g] = out_pkt;
    end

    assign il_bits = req_pkt.addr >> interleave_shift_p;
    assign il_link = link_width_lp'(il_bits & addr_width_gp'(num_links_p - 1));

    // Round-robin scan runs backwards so the link nearest rr_ptr wins last.
    always_comb begin
        sel_v    = 1'b0;
        sel_link = '0;
        if (mode_q == e_link_interleave) begin
            sel_link = il_link;
            sel_v    = link_ok[il_link];
        end else begin
            for (int i = num_links_p - 1; i >= 0; i--) begin
                if (link_ok[(int'(rr_ptr_q) + i) % num_links_p]) begin
                    sel_v    = 1'b1;
                    sel_link = link_width_lp'((int'(rr_ptr_q) + i) % num_links_p);
                end
            end
        end
    end

    assign rr_ptr_d = link_width_lp'((int'(sel_link) + 1) % num_links_p);
    assign issue    = ~reset_i & bus.req_v_i & ~rob_full & sel_v;
    assign out_pkt  = set_reg_id(req_pkt, reg_id_width_gp'(alloc_tag));

    assign bus.req_ready_o     = issue;
    assign bus.out_v_o         = issue ? (num_links_p'(1) << sel_link) : '0;
    assign ret_v               = bus.returned_v_r_i & {num_links_p{~reset_i}};
    assign bus.returned_yumi_o = ret_v;
    assign bus.resp_v_o        = head_v & ~reset_i;
    assign retire              = bus.resp_yumi_i & bus.resp_v_o;

    // Mode only changes while nothing is in flight, so tags never straddle modes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
            mode_q   <= e_link_rr;
        end else begin
            if (issue)
                rr_ptr_q <= rr_ptr_d;
            if (rob_empty && !issue)
                mode_q <= link_mode_e'(bus.mode_i);
        end
    end

    brg_cgra_rob #(
        .depth_p      (max_inflight_p),
        .num_ports_p  (num_links_p),
        .data_width_p (data_width_p),
        .tag_width_p  (tag_width_lp)
    ) u_rob (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .alloc_v_i   (issue),
        .alloc_tag_o (alloc_tag),
        .full_o      (rob_full),
        .empty_o     (rob_empty),
        .wr_v_i      (ret_v),
        .wr_tag_i    (bus.returned_reg_id_r_i),
        .wr_data_i   (bus.returned_data_r_i),
        .head_v_o    (head_v),
        .head_data_o (bus.resp_data_o),
        .retire_i    (retire)
    );

endmodule

// File: tb/tb_brg_cgra_multi_link_master.sv
// Scenario bench for the multi-link master: link dispatch, credit stall,
// response reordering, full/wrap and mid-flight reset.
module tb_brg_cgra_multi_link_master;
    import brg_cgra_xcel_pkg::*;

    localparam int NL    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(32 + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    brg_cgra_multi_link_master_if #(
        .num_links_p(NL), .data_width_p(data_width_gp),
        .packet_width_p(packet_width_gp), .credit_width_p(CW)
    ) bus ();

    brg_cgra_multi_link_master #(
        .num_links_p(NL), .max_inflight_p(DEPTH), .interleave_shift_p(2),
        .max_out_credits_p(32)
    ) dut (
        .clk_i(clk), .reset_i(rst), .bus(bus)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_resp[$];
    int          pend_tags[$];
    logic [31:0] tag_data[DEPTH];
    int          next_tag = 0;
    int          exp_rr = 0;
    int          seq = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_v_i             = 1'b0;
        bus.req_packet_i        = '0;
        bus.returned_v_r_i      = '0;
        bus.returned_reg_id_r_i = '0;
        bus.returned_data_r_i   = '0;
        bus.resp_yumi_i         = 1'b0;
    endtask

    function automatic bsg_manycore_packet_s mk_pkt(input logic [addr_width_gp-1:0] addr);
        bsg_manycore_packet_s p;
        p         = '0;
        p.addr    = addr;
        p.op_ex   = 4'hF;
        p.reg_id  = 5'h1F;
        p.payload = {4'h5, addr};
        p.x_cord  = 4'h3;
        p.y_cord  = 4'h2;
        return p;
    endfunction

    task automatic issue_one(input logic [addr_width_gp-1:0] addr, input int exp_link);
        bsg_manycore_packet_s p, o;
        logic [31:0] d;
        p = mk_pkt(addr);
        bus.req_v_i      = 1'b1;
        bus.req_packet_i = p;
        @(negedge clk);
        o = bus.out_packet_o[exp_link];
        n_vec++;
        if (bus.req_ready_o !== 1'b1 || bus.out_v_o !== 4'(1 << exp_link)) begin
            n_bad++;
            $display("FAIL issue_handshake addr=%h: ready=%b out_v=%b, want ready=1 out_v=%b",
                     addr, bus.req_ready_o, bus.out_v_o, 4'(1 << exp_link));
        end
        n_vec++;
        if (o.reg_id !== 5'(next_tag) || o.addr !== addr || o.payload !== p.payload) begin
            n_bad++;
            $display("FAIL issue_packet addr=%h: reg_id=%0d addr=%h, want reg_id=%0d addr=%h",
                     addr, o.reg_id, o.addr, next_tag, addr);
        end
        d = {8'hD0, 16'(seq), 8'(next_tag)};
        exp_resp.push_back(d);
        pend_tags.push_back(next_tag);
        tag_data[next_tag] = d;
        next_tag = (next_tag + 1) % DEPTH;
        exp_rr   = (exp_link + 1) % NL;
        seq++;
        next_cyc();
        bus.req_v_i = 1'b0;
    endtask

    task automatic ret_set(input logic [NL-1:0] mask, input int t0, input int t1,
                           input int t2, input int t3);
        int t[NL];
        t = '{t0, t1, t2, t3};
        bus.returned_v_r_i = mask;
        for (int i = 0; i < NL; i++) begin
            bus.returned_reg_id_r_i[i] = 5'(t[i]);
            bus.returned_data_r_i[i]   = tag_data[t[i] % DEPTH];
        end
        @(negedge clk);
        n_vec++;
        if (bus.returned_yumi_o !== mask) begin
            n_bad++;
            $display("FAIL return_yumi: yumi=%b, want %b", bus.returned_yumi_o, mask);
        end
        next_cyc();
        bus.returned_v_r_i = '0;
    endtask

    task automatic drain_returns();
        foreach (pend_tags[k])
            ret_set(4'(1 << (pend_tags[k] % NL)), pend_tags[k], pend_tags[k],
                    pend_tags[k], pend_tags[k]);
        pend_tags.delete();
    endtask

    task automatic collect(input int budget);
        logic [31:0] d;
        int b;
        b = budget;
        bus.resp_yumi_i = 1'b1;
        while (exp_resp.size() > 0 && b > 0) begin
            @(negedge clk);
            if (bus.resp_v_o === 1'b1) begin
                d = exp_resp.pop_front();
                n_vec++;
                if (bus.resp_data_o !== d) begin
                    n_bad++;
                    $display("FAIL resp_data: got %h, want %h", bus.resp_data_o, d);
                end
            end
            b--;
            next_cyc();
        end
        bus.resp_yumi_i = 1'b0;
        n_vec++;
        if (exp_resp.size() != 0) begin
            n_bad++;
            $display("FAIL resp_timeout: %0d responses missing, want 0", exp_resp.size());
            exp_resp.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.mode_i                = 1'b0;
        bus.out_credit_or_ready_i = '1;
        for (int i = 0; i < NL; i++) bus.out_credits_i[i] = CW'(4);
        bus.req_v_i        = 1'b1;
        bus.req_packet_i   = mk_pkt('0);
        bus.returned_v_r_i = '1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if (bus.req_ready_o !== 1'b0 || bus.out_v_o !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_issue: ready=%b out_v=%b, want 0 0000", bus.req_ready_o, bus.out_v_o);
        end
        n_vec++;
        if (bus.returned_yumi_o !== 4'b0 || bus.resp_v_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_return: yumi=%b resp_v=%b, want 0000 0",
                     bus.returned_yumi_o, bus.resp_v_o);
        end
        next_cyc();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (bus.resp_v_o !== 1'b0 || bus.req_ready_o !== 1'b0 || bus.out_v_o !== 4'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: resp_v=%b ready=%b out_v=%b, want 0 0 0000",
                     bus.resp_v_o, bus.req_ready_o, bus.out_v_o);
        end
        next_cyc();
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 8; k++) issue_one(addr_width_gp'(k * 32), k % NL);
        drain_returns();
        collect(40);
    endtask

    task automatic test_interleave();
        bus.mode_i = 1'b1;
        next_cyc();
        issue_one(28'h0, 0);
        issue_one(28'h4, 1);
        issue_one(28'h8, 2);
        issue_one(28'hC, 3);
        issue_one(28'h10, 0);
        drain_returns();
        collect(40);
    endtask

    task automatic test_credit_stall();
        bus.out_credits_i[2] = '0;
        bus.req_v_i          = 1'b1;
        bus.req_packet_i     = mk_pkt(28'h8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.req_ready_o !== 1'b0 || bus.out_v_o !== 4'b0) begin
                n_bad++;
                $display("FAIL credit_stall cycle %0d: ready=%b out_v=%b, want 0 0000",
                         c, bus.req_ready_o, bus.out_v_o);
            end
            next_cyc();
        end
        bus.out_credits_i[2] = CW'(1);
        issue_one(28'h8, 2);
        bus.out_credits_i[2] = CW'(4);
        drain_returns();
        collect(20);
        bus.mode_i = 1'b0;
        next_cyc();
    endtask

    task automatic test_reorder();
        int ta[4];
        for (int i = 0; i < 4; i++) begin
            ta[i] = next_tag;
            issue_one(addr_width_gp'(i * 64), exp_rr);
        end
        ret_set(4'b1000, 0, 0, 0, ta[3]);
        ret_set(4'b0110, 0, ta[1], ta[2], 0);
        @(negedge clk);
        n_vec++;
        if (bus.resp_v_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reorder_hold: resp_v=%b, want 0 before oldest returns", bus.resp_v_o);
        end
        next_cyc();
        ret_set(4'b0001, ta[0], 0, 0, 0);
        bus.resp_yumi_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            @(negedge clk);
            d = exp_resp.pop_front();
            n_vec++;
            if (bus.resp_v_o !== 1'b1 || bus.resp_data_o !== d) begin
                n_bad++;
                $display("FAIL reorder_out %0d: resp_v=%b data=%h, want 1 %h",
                         i, bus.resp_v_o, bus.resp_data_o, d);
            end
            next_cyc();
        end
        bus.resp_yumi_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.resp_v_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reorder_empty: resp_v=%b, want 0", bus.resp_v_o);
        end
        next_cyc();
        pend_tags.delete();
    endtask

    task automatic test_full_wrap();
        int tg;
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) issue_one(addr_width_gp'(i * 4), exp_rr);
        bus.req_v_i      = 1'b1;
        bus.req_packet_i = mk_pkt(28'h3FC);
        @(negedge clk);
        n_vec++;
        if (bus.req_ready_o !== 1'b0 || bus.out_v_o !== 4'b0) begin
            n_bad++;
            $display("FAIL full_block: ready=%b out_v=%b, want 0 0000", bus.req_ready_o, bus.out_v_o);
        end
        next_cyc();
        tg = pend_tags.pop_front();
        ret_set(4'(1 << (tg % NL)), tg, tg, tg, tg);
        bus.resp_yumi_i = 1'b1;
        @(negedge clk);
        d = exp_resp.pop_front();
        n_vec++;
        if (bus.resp_v_o !== 1'b1 || bus.resp_data_o !== d || bus.req_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL full_retire: resp_v=%b data=%h ready=%b, want 1 %h 0",
                     bus.resp_v_o, bus.resp_data_o, bus.req_ready_o, d);
        end
        next_cyc();
        bus.resp_yumi_i = 1'b0;
        issue_one(28'h3FC, exp_rr);
        drain_returns();
        collect(60);
    endtask

    task automatic test_reset_mid();
        int q[3];
        for (int i = 0; i < 3; i++) begin
            q[i] = next_tag;
            issue_one(addr_width_gp'(i * 16), exp_rr);
        end
        ret_set(4'(1 << (q[0] % NL)), q[0], q[0], q[0], q[0]);
        @(negedge clk);
        n_vec++;
        if (bus.resp_v_o !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_head_valid: resp_v=%b, want 1", bus.resp_v_o);
        end
        next_cyc();
        rst                        = 1'b1;
        bus.req_v_i                = 1'b1;
        bus.req_packet_i           = mk_pkt(28'h0);
        bus.returned_v_r_i         = 4'b0010;
        bus.returned_reg_id_r_i[1] = 5'(q[1]);
        @(negedge clk);
        n_vec++;
        if (bus.req_ready_o !== 1'b0 || bus.out_v_o !== 4'b0 ||
            bus.returned_yumi_o !== 4'b0 || bus.resp_v_o !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: ready=%b out_v=%b yumi=%b resp_v=%b, want all 0",
                     bus.req_ready_o, bus.out_v_o, bus.returned_yumi_o, bus.resp_v_o);
        end
        next_cyc();
        rst                        = 1'b0;
        bus.req_v_i                = 1'b0;
        bus.returned_v_r_i         = 4'b0111;
        bus.returned_reg_id_r_i[0] = 5'd0;
        bus.returned_reg_id_r_i[1] = 5'(q[1]);
        bus.returned_reg_id_r_i[2] = 5'(q[2]);
        @(negedge clk);
        n_vec++;
        if (bus.returned_yumi_o !== 4'b0111 || bus.resp_v_o !== 1'b0) begin
            n_bad++;
            $display("FAIL late_return_yumi: yumi=%b resp_v=%b, want 0111 0",
                     bus.returned_yumi_o, bus.resp_v_o);
        end
        next_cyc();
        bus.returned_v_r_i = '0;
        @(negedge clk);
        n_vec++;
        if (bus.resp_v_o !== 1'b0) begin
            n_bad++;
            $display("FAIL late_return_dropped: resp_v=%b, want 0", bus.resp_v_o);
        end
        next_cyc();
        exp_resp.delete();
        pend_tags.delete();
        next_tag = 0;
        exp_rr   = 0;
        issue_one(28'h40, 0);
        drain_returns();
        collect(20);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_interleave();
        test_credit_stall();
        test_reorder();
        test_full_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
